// File: rtl/ysyx_201979054_div_pkg.sv
// Shared definitions for the divide/remainder unit.
// - Division operation codes, also emitted by the ALU decoder on alu_control.
// - FSM state encoding.
// - Iteration counts: 64 for full-width ops, 32 for W ops.
// - Small helpers that classify an operation code.
package ysyx_201979054_div_pkg;

  localparam logic [4:0] ALU_DIVU  = 5'b10101;
  localparam logic [4:0] ALU_REMU  = 5'b10111;
  localparam logic [4:0] ALU_DIVUW = 5'b10110;
  localparam logic [4:0] ALU_REMUW = 5'b11000;
  localparam logic [4:0] ALU_DIVW  = 5'b10011;

  localparam logic [6:0] DIV_ITER_D = 7'd64;
  localparam logic [6:0] DIV_ITER_W = 7'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIVU) || (code == ALU_REMU) || (code == ALU_DIVUW) ||
           (code == ALU_REMUW) || (code == ALU_DIVW);
  endfunction

  function automatic logic is_w_op(input logic [4:0] code);
    return (code == ALU_DIVUW) || (code == ALU_REMUW) || (code == ALU_DIVW);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] code);
    return (code == ALU_REMU) || (code == ALU_REMUW);
  endfunction

endpackage

// File: rtl/ysyx_201979054_div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem, quo, divisor : current partial remainder, dividend/quotient shift register, divisor
//   rem_next, quo_next: state after shifting {rem, quo} left by one and conditionally subtracting
module ysyx_201979054_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted remainder needs one extra bit: it is below 2*divisor and can exceed XLEN bits.
  logic        [XLEN:0] rem_sh;
  logic signed [XLEN:0] diff;
  logic                 ge;

  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = $signed(rem_sh) - $signed({1'b0, divisor});
    // The difference always lies in (-divisor, divisor), so the top bit is a clean borrow flag.
    ge       = ~diff[XLEN];
    rem_next = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ge};
  end

endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// Multi-cycle integer divide/remainder unit (radix-2 restoring).
// Supported ops: DIVU, REMU, DIVUW, REMUW, DIVW.
// Ports:
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_start, i_alu_control     : launch request and operation code (sampled in IDLE)
//   i_src_1, i_src_2           : dividend, divisor (captured with the start)
//   o_busy                     : high in every non-IDLE state
//   o_done, o_illegal          : one-cycle pulses; o_illegal flags a non-division code
//   o_result                   : quotient/remainder, valid with o_done and held afterwards
// Build option: DIV_ZERO_EARLY_OUT_EN - a zero divisor skips the iterations and finishes from PREP.
module ysyx_201979054_div_unit
  import ysyx_201979054_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [4:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_1,
  input  logic [XLEN-1:0] i_src_2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  div_state_e      state;
  logic [6:0]      cnt_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic            neg_q;
  logic [XLEN-1:0] rem_next, quo_next;

  logic               w_op;
  logic signed [31:0] a_lo, b_lo;
  logic [31:0]        dvd_lo, dvs_lo;
  logic               neg_prep;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] fix_result(input logic [4:0] op, input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] rem, input logic neg);
    logic [31:0] q32;
    q32 = neg ? (32'd0 - quo[31:0]) : quo[31:0];
    case (op)
      ALU_DIVU:  return quo;
      ALU_REMU:  return rem;
      ALU_DIVUW: return sext32(quo[31:0]);
      ALU_REMUW: return sext32(rem[31:0]);
      ALU_DIVW:  return sext32(q32);
      default:   return '0;
    endcase
  endfunction

  ysyx_201979054_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand preparation from the captured sources (used in PREP).
  always_comb begin
    w_op     = is_w_op(op_q);
    a_lo     = $signed(src1_q[31:0]);
    b_lo     = $signed(src2_q[31:0]);
    dvd_lo   = src1_q[31:0];
    dvs_lo   = src2_q[31:0];
    neg_prep = 1'b0;
    if (op_q == ALU_DIVW) begin
      dvd_lo   = a_lo[31] ? 32'(-a_lo) : 32'(a_lo);
      dvs_lo   = b_lo[31] ? 32'(-b_lo) : 32'(b_lo);
      neg_prep = (a_lo[31] ^ b_lo[31]) && (b_lo != 32'sd0);
    end
  end

`ifdef DIV_ZERO_EARLY_OUT_EN
  logic            dvs_zero;
  logic [XLEN-1:0] zero_result;

  always_comb begin
    dvs_zero    = w_op ? (dvs_lo == 32'd0) : (src2_q == '0);
    zero_result = '1;
    if (is_rem_op(op_q))
      zero_result = w_op ? sext32(src1_q[31:0]) : src1_q;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_q     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_illegal <= 1'b0;
      o_result  <= '0;
    end else begin
      o_done    <= 1'b0;
      o_illegal <= 1'b0;
      case (state)
        // IDLE: accept a start; illegal codes finish immediately.
        ST_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (is_div_op(i_alu_control)) begin
              op_q   <= i_alu_control;
              src1_q <= i_src_1;
              src2_q <= i_src_2;
              state  <= ST_PREP;
            end else begin
              o_done    <= 1'b1;
              o_illegal <= 1'b1;
              o_result  <= '0;
              state     <= ST_DONE;
            end
          end
        end
        // PREP: W ops park the 32-bit dividend in the upper half so 32 shifts consume it.
        ST_PREP: begin
          rem_q <= '0;
          quo_q <= w_op ? {dvd_lo, 32'd0} : src1_q;
          div_q <= w_op ? {{(XLEN-32){1'b0}}, dvs_lo} : src2_q;
          neg_q <= neg_prep;
          cnt_q <= w_op ? DIV_ITER_W : DIV_ITER_D;
`ifdef DIV_ZERO_EARLY_OUT_EN
          if (dvs_zero) begin
            o_result <= zero_result;
            o_done   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_CALC;
          end
`else
          state <= ST_CALC;
`endif
        end
        // CALC: one restoring step per cycle.
        ST_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) state <= ST_FIX;
        end
        // FIX: select, sign-correct and extend the result.
        ST_FIX: begin
          o_result <= fix_result(op_q, quo_q, rem_q, neg_q);
          o_done   <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
module tb_ysyx_201979054_div_unit;

  localparam logic [4:0] C_DIVU  = 5'b10101;
  localparam logic [4:0] C_REMU  = 5'b10111;
  localparam logic [4:0] C_DIVUW = 5'b10110;
  localparam logic [4:0] C_REMUW = 5'b11000;
  localparam logic [4:0] C_DIVW  = 5'b10011;

`ifdef DIV_ZERO_EARLY_OUT_EN
  localparam int ZLAT64 = 2;
  localparam int ZLAT32 = 2;
`else
  localparam int ZLAT64 = 67;
  localparam int ZLAT32 = 35;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [4:0]  i_alu_control = '0;
  logic [63:0] i_src_1 = '0;
  logic [63:0] i_src_2 = '0;
  logic        o_busy, o_done, o_illegal;
  logic [63:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  ysyx_201979054_div_unit #(.XLEN(64)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_alu_control (i_alu_control),
    .i_src_1       (i_src_1),
    .i_src_2       (i_src_2),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_illegal     (o_illegal)
  );

  // Launch one op and wait (bounded) for done. lat counts clock edges from the start edge
  // (inclusive) to the edge that raised o_done; 200 means it never came.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output logic ill,
                        output logic done_after);
    @(negedge i_clk);
    i_alu_control = op;
    i_src_1 = a;
    i_src_2 = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = 1;
    while (!o_done && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    res = o_result;
    ill = o_illegal;
    @(posedge i_clk);
    #1;
    done_after = o_done;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_illegal !== 1'b0 || o_result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b illegal=%b result=%h, required 0/0/0/0",
               o_busy, o_done, o_illegal, o_result);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_divu_remu();
    logic [63:0] r; int lat; logic ill, da;
    run_op(C_DIVU, 64'd100, 64'd7, r, lat, ill, da);
    n_tests++;
    if (r !== 64'd14) begin n_fail++; $display("FAIL divu_100_7: got %h, required %h", r, 64'd14); end
    n_tests++;
    if (lat !== 67) begin n_fail++; $display("FAIL divu_latency: got %0d, required 67", lat); end
    n_tests++;
    if (ill !== 1'b0 || da !== 1'b0) begin
      n_fail++; $display("FAIL divu_pulse: illegal=%b done_next=%b, required 0/0", ill, da);
    end
    run_op(C_REMU, 64'd100, 64'd7, r, lat, ill, da);
    n_tests++;
    if (r !== 64'd2) begin n_fail++; $display("FAIL remu_100_7: got %h, required %h", r, 64'd2); end
    run_op(C_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, r, lat, ill, da);
    n_tests++;
    if (r !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++; $display("FAIL divu_wide: got %h, required %h", r, 64'h0000_0000_FFFF_FFFF);
    end
  endtask

  task automatic test_divw();
    logic [63:0] r; int lat; logic ill, da;
    run_op(C_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL divw_m7_2: got %h, required %h", r, 64'hFFFF_FFFF_FFFF_FFFD);
    end
    n_tests++;
    if (lat !== 35) begin n_fail++; $display("FAIL divw_latency: got %0d, required 35", lat); end
    run_op(C_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++; $display("FAIL divw_overflow: got %h, required %h", r, 64'hFFFF_FFFF_8000_0000);
    end
    run_op(C_DIVW, 64'd20, 64'hFFFF_FFFF_FFFF_FFFB, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL divw_20_m5: got %h, required %h", r, 64'hFFFF_FFFF_FFFF_FFFC);
    end
  endtask

  task automatic test_divuw_remuw();
    logic [63:0] r; int lat; logic ill, da;
    run_op(C_DIVUW, 64'h0000_0001_FFFF_FFFF, 64'd1, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL divuw_sext: got %h, required %h", r, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    n_tests++;
    if (lat !== 35) begin n_fail++; $display("FAIL divuw_latency: got %0d, required 35", lat); end
    run_op(C_REMUW, 64'h0000_0000_8000_0005, 64'h10, r, lat, ill, da);
    n_tests++;
    if (r !== 64'd5) begin n_fail++; $display("FAIL remuw_5: got %h, required %h", r, 64'd5); end
  endtask

  task automatic test_div_zero();
    logic [63:0] r; int lat; logic ill, da;
    run_op(C_DIVU, 64'd12345, 64'd0, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL divu_zero: got %h, required all ones", r);
    end
    n_tests++;
    if (lat !== ZLAT64) begin
      n_fail++; $display("FAIL divu_zero_latency: got %0d, required %0d", lat, ZLAT64);
    end
    run_op(C_REMU, 64'h1234, 64'd0, r, lat, ill, da);
    n_tests++;
    if (r !== 64'h1234) begin n_fail++; $display("FAIL remu_zero: got %h, required %h", r, 64'h1234); end
    run_op(C_REMUW, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_8000_0001) begin
      n_fail++; $display("FAIL remuw_zero: got %h, required %h", r, 64'hFFFF_FFFF_8000_0001);
    end
    n_tests++;
    if (lat !== ZLAT32) begin
      n_fail++; $display("FAIL remuw_zero_latency: got %0d, required %0d", lat, ZLAT32);
    end
    run_op(C_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, r, lat, ill, da);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL divw_zero: got %h, required all ones", r);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] r; int lat; logic ill, da;
    run_op(5'b00000, 64'd55, 64'd5, r, lat, ill, da);
    n_tests++;
    if (lat !== 1 || ill !== 1'b1 || r !== 64'd0) begin
      n_fail++;
      $display("FAIL illegal_code: lat=%0d illegal=%b result=%h, required 1/1/0", lat, ill, r);
    end
    n_tests++;
    if (da !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse: done_next=%b busy=%b, required 0/0", da, o_busy);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge i_clk);
    i_alu_control = C_DIVU; i_src_1 = 64'd100; i_src_2 = 64'd7; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b, required 1", o_busy); end
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_alu_control = C_REMU; i_src_1 = 64'd50; i_src_2 = 64'd3; i_start = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = 9;
    while (!o_done && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    n_tests++;
    if (o_result !== 64'd14 || lat !== 67) begin
      n_fail++; $display("FAIL busy_ignore: result=%h lat=%0d, required %h/67", o_result, lat, 64'd14);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_rst_mid();
    logic [63:0] r; int lat; logic ill, da;
    int done_cnt;
    @(negedge i_clk);
    i_alu_control = C_DIVU; i_src_1 = 64'd1000; i_src_2 = 64'd3; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (21) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b result=%h, required 0/0/0", o_busy, o_done, o_result);
    end
    done_cnt = 0;
    repeat (80) begin
      @(posedge i_clk);
      #1;
      if (o_done) done_cnt++;
    end
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++; $display("FAIL rst_no_done: got %0d pulses, required 0", done_cnt);
    end
    run_op(C_DIVU, 64'd9, 64'd3, r, lat, ill, da);
    n_tests++;
    if (r !== 64'd3) begin n_fail++; $display("FAIL after_rst_divu: got %h, required %h", r, 64'd3); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2; int lat1, lat2; logic ill, da;
    run_op(C_DIVUW, 64'd77, 64'd7, r1, lat1, ill, da);
    run_op(C_REMU, 64'd77, 64'd10, r2, lat2, ill, da);
    n_tests++;
    if (r1 !== 64'd11 || r2 !== 64'd7) begin
      n_fail++; $display("FAIL back_to_back: got %h,%h, required %h,%h", r1, r2, 64'd11, 64'd7);
    end
    n_tests++;
    if (lat1 !== 35 || lat2 !== 67) begin
      n_fail++; $display("FAIL back_to_back_latency: got %0d,%0d, required 35,67", lat1, lat2);
    end
  endtask

  initial begin
    test_reset();
    test_divu_remu();
    test_divw();
    test_divuw_remuw();
    test_div_zero();
    test_illegal();
    test_busy_ignore();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_201979054_div_unit.md
# ysyx_201979054_div_unit

Multi-cycle integer divide/remainder unit for the RV64 core: the execution-side consumer of the division codes that the ALU decoder emits on `alu_control`. It accepts one operation per start pulse and iterates a radix-2 restoring divider. It returns a 64-bit result with a one-cycle done pulse. It sits beside the single-cycle ALU, and the control FSM stalls on `o_busy`.

## Interface
- `XLEN`, default 64: datapath width; only 64 is supported.
- `i_clk` in 1: core clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: launch request; sampled only in IDLE.
- `i_alu_control` in 5: operation code, captured with `i_start`.
- `i_src_1` in XLEN: dividend.
- `i_src_2` in XLEN: divisor.
- `o_busy` in/out: out 1; high in every non-IDLE state.
- `o_done` out 1: one-cycle pulse; `o_result` is valid in that cycle.
- `o_result` out XLEN: quotient or remainder; held until the next accepted start.
- `o_illegal` out 1: one-cycle pulse, coincident with `o_done`, when the captured code is not a division code.

## Operation
- Codes:
  - 5'b10101 DIVU: 64-bit unsigned quotient.
  - 5'b10111 REMU: 64-bit unsigned remainder.
  - 5'b10110 DIVUW: quotient of low 32 bits, unsigned.
  - 5'b11000 REMUW: remainder of low 32 bits, unsigned.
  - 5'b10011 DIVW: quotient of low 32 bits, signed.
- Any other code with `i_start` goes IDLE→DONE. `o_done`=1, `o_illegal`=1, `o_result`=0.
- FSM: IDLE → PREP → CALC → FIX → DONE → IDLE.
  - PREP: capture operands. For W ops, take the low 32 bits. For DIVU/DIVUW/REMU/REMUW, zero-extend. For DIVW, latch the sign of each operand and take the 32-bit magnitude of each. Load iteration count N: 64 for non-W ops, 32 for W ops.
  - CALC: one restoring step per cycle. Shift {rem, quo} left by 1, subtract the divisor from rem, keep the difference if non-negative and set the quotient LSB to 1. Counter decrements; exit when it reaches 0.
  - FIX: select quotient or remainder.
    - DIVW: negate the 32-bit quotient if the operand signs differ and the divisor is non-zero.
    - W ops: sign-extend result bit 31 to 64 bits, including DIVUW and REMUW.
  - DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Divide by zero:
  - Quotient is all ones: DIVU → 0xFFFF_FFFF_FFFF_FFFF; DIVUW and DIVW → 0xFFFF_FFFF_FFFF_FFFF after sign extension.
  - Remainder equals the dividend; REMUW is sign-extended from bit 31.
- Signed overflow, DIVW −2^31 / −1: result 0xFFFF_FFFF_8000_0000. This falls out naturally; no special case is needed.
- `i_start` while busy is ignored, and operands are not re-sampled.

## Timing
- Reset: state IDLE; `o_busy`=0, `o_done`=0, `o_illegal`=0, `o_result`=0; counter and internal registers are cleared.
- Start sampled at edge k:
  - PREP is at cycle k+1, CALC covers N cycles, FIX follows, and `o_done` is high at cycle k+N+3.
  - Latency: 67 cycles for 64-bit ops, 35 for W ops.
  - An illegal code gives `o_done` at k+1.
- A start may be accepted in the cycle after DONE, since the FSM is in IDLE again. No back-to-back acceptance in the DONE cycle itself.
- Reset mid-operation: abort, return to IDLE next cycle with all outputs at reset values; no done pulse.

## Configuration
- `DIV_ZERO_EARLY_OUT_EN` defined:
  - In PREP, a zero divisor (after W masking) jumps directly to DONE with the divide-by-zero result.
  - Latency is 2 cycles for every op, with done at k+2.
- `DIV_ZERO_EARLY_OUT_EN` undefined: a zero divisor runs the full N iterations. Result values are identical.

## Structure
- Package `ysyx_201979054_div_pkg`: localparams for the five division codes (shared with the ALU decoder), the FSM state enum, and iteration-count constants 64 and 32.
- Sub-module `ysyx_201979054_div_step`: combinational single restoring iteration. Inputs {rem, quo, divisor}; outputs {rem_next, quo_next}. The FSM and counter stay in the top module.

## Test plan
- DIVU 100/7 → `o_result`=14 with `o_done` exactly 67 cycles after the start edge. REMU 100/7 → 2.
- DIVW src1=0xFFFF_FFFF_FFFF_FFF9 (−7), src2=2 → 0xFFFF_FFFF_FFFF_FFFD (−3) at 35 cycles. Overflow case −2^31 / −1 → 0xFFFF_FFFF_8000_0000.
- DIVUW src1=0x1_FFFF_FFFF, src2=1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended). REMUW 0x8000_0005 / 0x10 → 0x5.
- Divide by zero: DIVU x/0 → all ones; REMU 0x1234/0 → 0x1234. Latency is 67 without the macro and 2 with `DIV_ZERO_EARLY_OUT_EN`.
- Code 5'b00000 with start → `o_done`=`o_illegal`=1 next cycle, result 0. A second start asserted while busy is ignored, and the first result is unchanged.
- Assert `i_rst` at CALC cycle 20 → next cycle IDLE, `o_busy`=0, `o_result`=0, no `o_done`. A subsequent DIVU 9/3 → 3.
